biquad8_pole_coeff_ctrl: RTL
============================

// Module: biquad8_pole_coeff_ctrl
// PURPOSE
//  Coefficient load sequencer for the 4-DSP 2x2 pole IIR (A,B,C,D matrix).
//  Holds a host-writable shadow copy of A..D and, on commit, shifts the four
//  words down the DSP B-cascade chain (CEB1 strobe), then pulses the global
//  B2 update (CEB2) so all four coefficients switch in the same cycle.
//  Sits between the register/control bus and biquad8_pole_iir coeff_* inputs.
// PARAMETERS
//  COEFF_BITS    18        coefficient width (DSP B port)
//  INIT_A        18'd0     reset value of shadow A (dsp0 coefficient)
//  INIT_B        18'd0     reset value of shadow B (dsp1)
//  INIT_C        18'd0     reset value of shadow C (dsp2)
//  INIT_D        18'd0     reset value of shadow D (dsp3)
//  LOAD_ON_RESET 1         1: load INIT_* into the DSPs automatically after reset
// PORTS
//  clk             in   1           clock; all logic in this domain
//  rst             in   1           asynchronous reset, active-high
//  s_wr_i          in   1           shadow write strobe
//  s_addr_i        in   2           0=A 1=B 2=C 3=D
//  s_dat_i         in   COEFF_BITS  shadow write data
//  s_commit_i      in   1           request load of shadow into DSPs
//  busy_o          out  1           load sequence in progress
//  done_o          out  1           1-cycle pulse, coincident with coeff_update_o
//  coeff_dat_o     out  COEFF_BITS  to biquad coeff_dat_i
//  coeff_wr_o      out  1           to biquad coeff_wr_i (B1 shift)
//  coeff_update_o  out  1           to biquad coeff_update_i (B2 load)
// BEHAVIOUR
//  - Reset (async): all outputs 0; shadow = INIT_A..D; pending=0; state IDLE.
//  - Shadow writes accepted every cycle, any state (no ready/backpressure).
//  - Commit accepted in IDLE: snapshot reg <= shadow (same-cycle s_wr_i is
//    applied first, i.e. included in snapshot); go SHIFT.
//  - FSM IDLE -> SHIFT(4 cycles, cnt 3..0) -> UPDATE(1) -> IDLE.
//  - Shift order D,C,B,A (first word ends in dsp3, last in dsp0).
//  - All outputs registered. Commit at edge t: coeff_wr_o=1 at t+1..t+4 with
//    coeff_dat_o=D,C,B,A; coeff_update_o=1 and done_o=1 at t+5, coeff_wr_o=0.
//    busy_o=1 t+1..t+5. coeff_dat_o holds last value when wr low.
//  - Commit while busy: sets pending (multiple collapse to one). On UPDATE
//    exit with pending: clear pending, re-snapshot shadow, go straight to
//    SHIFT (busy_o stays 1, no IDLE cycle).
//  - Shadow writes during SHIFT do not disturb the running sequence (snapshot).
//  - LOAD_ON_RESET=1: first cycle after rst deasserts behaves as an accepted
//    commit of INIT_* (coeff_wr_o at cycles 2..5, update at 6 after release).
//  - Reset mid-sequence: outputs drop immediately; biquad B2 keeps old coeffs
//    (no update issued); partially shifted B1 contents are harmless, the
//    next load overwrites all four.
//  - coeff_wr_o and coeff_update_o never high in the same cycle.
// STRUCTURE
//  - Shared include (biquad8 params): COEFF_BITS, NCOEFF=4, address codes
//    ADDR_A..ADDR_D, FSM state encodings.
//  - Single flat module; no sub-module (FSM + 2-bit counter + 2x4 regs).
// TESTING
//  - LOAD_ON_RESET=1, INIT=1,2,3,4: release rst -> wr pulses data 4,3,2,1,
//    then one update+done; biquad model holds A=1,B=2,C=3,D=4.
//  - Write A..D=0x100,0x200,0x300,0x3FFFF, commit -> 4 wr cycles in D..A
//    order, update at commit+5, busy 5 cycles.
//  - s_wr_i(addr 2,0x55) same cycle as s_commit_i in IDLE -> C=0x55 shifted.
//  - Commit, write D=0x7 at commit+2, commit again at commit+3 -> first load
//    uses old D; second sequence starts back-to-back after update, D=0x7.
//  - Assert rst at commit+3 -> outputs 0 immediately, no update; later commit
//    -> clean 4-word load, model coefficients correct.
//  - Assertion over all tests: never wr&update; exactly 4 wr before each update.

Source files
------------

// File: rtl/biquad8_pole_coeff_ctrl_pkg.sv
// biquad8_pole_coeff_ctrl_pkg: shared widths, address codes and FSM states
package biquad8_pole_coeff_ctrl_pkg;
    localparam int COEFF_BITS = 18;
    localparam int NCOEFF = 4;
    localparam logic [1:0] ADDR_A = 2'd0;
    localparam logic [1:0] ADDR_B = 2'd1;
    localparam logic [1:0] ADDR_C = 2'd2;
    localparam logic [1:0] ADDR_D = 2'd3;
    typedef logic [COEFF_BITS-1:0] coeff_t;
    // S_START replays a commit of the reset shadow values when LOAD_ON_RESET is set
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE, S_START} state_t;
endpackage

// File: rtl/biquad8_pole_coeff_ctrl_if.sv
// biquad8_pole_coeff_ctrl_if: host shadow bus plus coefficient load outputs
interface biquad8_pole_coeff_ctrl_if;
    import biquad8_pole_coeff_ctrl_pkg::*;
    logic       s_wr_i;
    logic [1:0] s_addr_i;
    coeff_t     s_dat_i;
    logic       s_commit_i;
    logic       busy_o;
    logic       done_o;
    coeff_t     coeff_dat_o;
    logic       coeff_wr_o;
    logic       coeff_update_o;
    modport slave (
        input  s_wr_i, s_addr_i, s_dat_i, s_commit_i,
        output busy_o, done_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );
    modport master (
        output s_wr_i, s_addr_i, s_dat_i, s_commit_i,
        input  busy_o, done_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );
endinterface

// File: rtl/biquad8_pole_coeff_ctrl.sv
// biquad8_pole_coeff_ctrl: shadows A..D and shifts them D,C,B,A into the DSP B1 cascade, then pulses B2 update
module biquad8_pole_coeff_ctrl
    import biquad8_pole_coeff_ctrl_pkg::*;
#(
    parameter coeff_t INIT_A = '0,
    parameter coeff_t INIT_B = '0,
    parameter coeff_t INIT_C = '0,
    parameter coeff_t INIT_D = '0,
    parameter bit     LOAD_ON_RESET = 1'b1
) (
    input logic clk,
    input logic rst,
    biquad8_pole_coeff_ctrl_if.slave ctrl_if
);
    state_t     state_q;
    logic [1:0] cnt_q;
    logic       pending_q;
    coeff_t     shadow_q [NCOEFF];
    coeff_t     shadow_d [NCOEFF];
    coeff_t     snap_q [NCOEFF];
    logic       busy_q, done_q, wr_q, update_q;
    coeff_t     dat_q;

    // same-cycle shadow write is visible to a commit snapshot
    always_comb begin
        for (int i = 0; i < NCOEFF; i++)
            shadow_d[i] = (ctrl_if.s_wr_i && ctrl_if.s_addr_i == 2'(i)) ? ctrl_if.s_dat_i : shadow_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD_ON_RESET ? S_START : S_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '{INIT_A, INIT_B, INIT_C, INIT_D};
            snap_q    <= '{default: '0};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            update_q  <= 1'b0;
            dat_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            case (state_q)
                S_IDLE, S_START: begin
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    wr_q      <= 1'b0;
                    update_q  <= 1'b0;
                    pending_q <= 1'b0;
                    if (ctrl_if.s_commit_i || state_q == S_START) begin
                        snap_q  <= shadow_d;
                        cnt_q   <= 2'd3;
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    wr_q     <= 1'b1;
                    update_q <= 1'b0;
                    dat_q    <= snap_q[cnt_q];
                    cnt_q    <= cnt_q - 2'd1;
                    if (ctrl_if.s_commit_i) pending_q <= 1'b1;
                    if (cnt_q == 2'd0) state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    busy_q   <= 1'b1;
                    done_q   <= 1'b1;
                    wr_q     <= 1'b0;
                    update_q <= 1'b1;
                    // a commit seen during the load restarts straight away, no idle gap
                    if (pending_q || ctrl_if.s_commit_i) begin
                        pending_q <= 1'b0;
                        snap_q    <= shadow_d;
                        cnt_q     <= 2'd3;
                        state_q   <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ctrl_if.busy_o         = busy_q;
    assign ctrl_if.done_o         = done_q;
    assign ctrl_if.coeff_wr_o     = wr_q;
    assign ctrl_if.coeff_update_o = update_q;
    assign ctrl_if.coeff_dat_o    = dat_q;
endmodule
